// File: rtl/counterdown16_monitor_1clk_posedge_sync_resetn.sv
// counterdown16_monitor_1clk_posedge_sync_resetn
// Posedge-side checker for a 16-bit free-running down counter that updates on
// negedge. Each posedge samples count_in and compares it with the previous
// sample. The classes are a normal step, a wrap (0x0000 -> 0xFFFF), a reload
// (0xFFFF from a nonzero value) and an illegal step.
// The block reports a saturating wrap count, a below-threshold flag and a
// sticky step error. Every output is driven from a flop.
//
// This block has no valid/ready handshake. A new sample is taken on every
// posedge while resetn is high. Each output reflects the sample taken at the
// most recent posedge.
module counterdown16_monitor_1clk_posedge_sync_resetn #(
  parameter logic [15:0] THRESH = 16'h0010,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clock0,
  input  logic              resetn,
  input  logic [15:0]       count_in,
  input  logic              clear,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              below_thresh,
  output logic              reload_seen,
  output logic              step_error,
  output logic              tracking,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       prev_count;
  logic [15:0]       prev_minus1;
  logic              classify;
  logic              cls_step;
  logic              cls_wrap;
  logic              cls_reload;
  logic              cls_error;
  logic              wrap_pulse_d;
  logic              reload_seen_d;
  logic              step_error_d;
  logic [WRAP_W-1:0] wrap_count_d;

  // Classify the current sample against the held reference.
  // The first matching class wins.
  always_comb begin
    prev_minus1 = prev_count - 16'd1;
    classify    = (state_q != S_IDLE);
    cls_step    = (prev_count != 16'd0) && (count_in == prev_minus1);
    cls_wrap    = (prev_count == 16'd0) && (count_in == 16'hFFFF);
    // p-1 can never be 0xFFFF when p is nonzero, so this class cannot overlap a normal step.
    cls_reload  = (prev_count != 16'd0) && (count_in == 16'hFFFF) && !cls_step;
    cls_error   = !(cls_step || cls_wrap || cls_reload);
  end

  // Compute the next state and the next statistics.
  // Clear beats a same-cycle error or wrap increment, but the wrap pulse still fires.
  always_comb begin
    state_d       = state_q;
    wrap_pulse_d  = 1'b0;
    reload_seen_d = 1'b0;
    step_error_d  = step_error;
    wrap_count_d  = wrap_count;

    case (state_q)
      S_IDLE: begin
        // The first sample only establishes the reference.
        state_d = S_TRACK;
      end
      S_TRACK, S_FAULT: begin
        wrap_pulse_d  = cls_wrap;
        reload_seen_d = cls_reload;
        if (cls_wrap && (wrap_count != WRAP_MAX)) begin
          wrap_count_d = wrap_count + 1'b1;
        end
        if (cls_error) begin
          step_error_d = 1'b1;
          state_d      = S_FAULT;
        end
        if (clear) begin
          wrap_count_d = '0;
          step_error_d = 1'b0;
          state_d      = S_TRACK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear still wipes the statistics while idle.
    // The IDLE -> TRACK transition is not affected.
    if (clear && !classify) begin
      wrap_count_d = '0;
      step_error_d = 1'b0;
    end
  end

  // Hold the state, the reference sample and all registered outputs.
  // Reset has priority over every other input.
  always_ff @(posedge clock0) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      prev_count   <= 16'd0;
      below_thresh <= 1'b0;
      wrap_pulse   <= 1'b0;
      reload_seen  <= 1'b0;
      step_error   <= 1'b0;
      wrap_count   <= '0;
    end else begin
      state_q      <= state_d;
      prev_count   <= count_in;
      below_thresh <= (count_in < THRESH);
      wrap_pulse   <= wrap_pulse_d;
      reload_seen  <= reload_seen_d;
      step_error   <= step_error_d;
      wrap_count   <= wrap_count_d;
    end
  end

  // Both outputs are decoded straight from the state flop, with no input in the path.
  always_comb begin
    tracking  = (state_q != S_IDLE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_counterdown16_monitor_1clk_posedge_sync_resetn.sv
// Directed bench for counterdown16_monitor_1clk_posedge_sync_resetn.
// Inputs change on negedge, like the real counter.
// Outputs are checked 1 ns after each posedge.
module tb_counterdown16_monitor_1clk_posedge_sync_resetn;

  localparam int unsigned WRAP_W = 2;

  // clock / reset block
  logic              clock0 = 1'b0;
  logic              resetn = 1'b0;
  logic [15:0]       count_in = 16'h0000;
  logic              clear = 1'b0;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              below_thresh;
  logic              reload_seen;
  logic              step_error;
  logic              tracking;
  logic [1:0]        state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock0 = ~clock0;

  counterdown16_monitor_1clk_posedge_sync_resetn #(
    .THRESH(16'h0010),
    .WRAP_W(WRAP_W)
  ) dut (
    .clock0      (clock0),
    .resetn      (resetn),
    .count_in    (count_in),
    .clear       (clear),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .below_thresh(below_thresh),
    .reload_seen (reload_seen),
    .step_error  (step_error),
    .tracking    (tracking),
    .state_dbg   (state_dbg)
  );

  // scoreboard: a single comparison point
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check every output at once.
  // Order: wrap_pulse, wrap_count, below_thresh, reload_seen, step_error, tracking, state.
  task automatic check_all(input string tag, input logic wp, input logic [WRAP_W-1:0] wc,
                           input logic bt, input logic rs, input logic se, input logic tr,
                           input logic [1:0] st);
    check_eq({tag, ".wrap_pulse"},   32'(wrap_pulse),   32'(wp));
    check_eq({tag, ".wrap_count"},   32'(wrap_count),   32'(wc));
    check_eq({tag, ".below_thresh"}, 32'(below_thresh), 32'(bt));
    check_eq({tag, ".reload_seen"},  32'(reload_seen),  32'(rs));
    check_eq({tag, ".step_error"},   32'(step_error),   32'(se));
    check_eq({tag, ".tracking"},     32'(tracking),     32'(tr));
    check_eq({tag, ".state"},        32'(state_dbg),    32'(st));
  endtask

  // driver tasks
  task automatic drive(input logic [15:0] v, input logic clr);
    @(negedge clock0);
    resetn   = 1'b1;
    count_in = v;
    clear    = clr;
    @(posedge clock0);
    #1;
  endtask

  // Assert reset for n posedges. Clear is held high to show that reset overrides it.
  task automatic do_reset(input int n);
    @(negedge clock0);
    resetn   = 1'b0;
    clear    = 1'b1;
    count_in = 16'hABCD;
    repeat (n) @(posedge clock0);
    #1;
  endtask

  initial begin
    // Reset, then check the threshold and the ramp down to a wrap.
    do_reset(2);
    check_all("reset0", 0, 0, 0, 0, 0, 0, 2'd0);

    drive(16'h0011, 1'b0);  // IDLE capture
    check_all("first_sample", 0, 0, 0, 0, 0, 1, 2'd1);
    drive(16'h0010, 1'b0);
    check_eq("thresh_0010", 32'(below_thresh), 32'd0);
    drive(16'h000F, 1'b0);
    check_eq("thresh_000F", 32'(below_thresh), 32'd1);
    for (int v = 14; v >= 0; v--) drive(16'(v), 1'b0);
    check_all("ramp_at_zero", 0, 0, 1, 0, 0, 1, 2'd1);
    drive(16'hFFFF, 1'b0);
    check_all("wrap1", 1, 1, 0, 0, 0, 1, 2'd1);
    drive(16'hFFFE, 1'b0);
    check_all("after_wrap", 0, 1, 0, 0, 0, 1, 2'd1);

    // Reload from 0xFFFE: it is neither a wrap nor an error.
    drive(16'hFFFF, 1'b0);
    check_all("reload_fffe", 0, 1, 0, 1, 0, 1, 2'd1);
    drive(16'hFFFE, 1'b0);
    check_all("reload_end", 0, 1, 0, 0, 0, 1, 2'd1);

    // Reload from an arbitrary value after a fresh reset.
    do_reset(1);
    check_all("reset1", 0, 0, 0, 0, 0, 0, 2'd0);
    drive(16'h1234, 1'b0);
    drive(16'h1233, 1'b0);
    check_all("step_1233", 0, 0, 0, 0, 0, 1, 2'd1);
    drive(16'hFFFF, 1'b0);
    check_all("reload_1233", 0, 0, 0, 1, 0, 1, 2'd1);

    // Illegal steps: a hold, then a skip, then clear.
    do_reset(1);
    drive(16'h0100, 1'b0);
    drive(16'h0100, 1'b0);
    check_all("hold_err", 0, 0, 0, 0, 1, 1, 2'd2);
    drive(16'h00FE, 1'b0);
    check_all("skip_err", 0, 0, 0, 0, 1, 1, 2'd2);
    drive(16'h00FD, 1'b1);
    check_all("clear_fault", 0, 0, 0, 0, 0, 1, 2'd1);
    drive(16'h00FC, 1'b0);
    check_all("post_clear_step", 0, 0, 0, 0, 0, 1, 2'd1);
    drive(16'h0050, 1'b1);  // error and clear in the same cycle
    check_all("clear_vs_err", 0, 0, 0, 0, 0, 1, 2'd1);

    // Saturation: each 0000 -> FFFF is a wrap, and each FFFF -> 0000 is an error.
    drive(16'h0000, 1'b0);
    check_all("to_zero_err", 0, 0, 1, 0, 1, 1, 2'd2);
    drive(16'hFFFF, 1'b0); check_all("sat_w1", 1, 1, 0, 0, 1, 1, 2'd2);
    drive(16'h0000, 1'b0); check_all("sat_z1", 0, 1, 1, 0, 1, 1, 2'd2);
    drive(16'hFFFF, 1'b0); check_all("sat_w2", 1, 2, 0, 0, 1, 1, 2'd2);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0); check_all("sat_w3", 1, 3, 0, 0, 1, 1, 2'd2);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0); check_all("sat_w4", 1, 3, 0, 0, 1, 1, 2'd2);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0); check_all("sat_w5", 1, 3, 0, 0, 1, 1, 2'd2);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b1);  // sixth wrap arrives together with clear
    check_all("clear_vs_wrap", 1, 0, 0, 0, 0, 1, 2'd1);

    // Reach FAULT with a saturated count, then reset in the middle of operation.
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0);
    check_all("pre_reset", 1, 3, 0, 0, 1, 1, 2'd2);
    do_reset(1);
    check_all("reset_mid", 0, 0, 0, 0, 0, 0, 2'd0);
    drive(16'h4321, 1'b0);  // discontinuous first sample is not classified
    check_all("post_reset_first", 0, 0, 0, 0, 0, 1, 2'd1);
    drive(16'h4320, 1'b0);
    check_all("post_reset_step", 0, 0, 0, 0, 0, 1, 2'd1);
    drive(16'h4320, 1'b0);
    check_all("post_reset_hold", 0, 0, 0, 0, 1, 1, 2'd2);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
